categorizador_stream: RTL
=========================

CATEGORIZADOR_STREAM -- requirements
Module: categorizador_stream

Interface
REQ-001 Parameter W, default 4, data width of sample p.
REQ-002 Parameter THRESH, default 13, high-class threshold; 0 < THRESH < 2^W.
REQ-003 Parameter CW, default 8, width of each statistics counter.
REQ-004 Parameter HALT_ON_ERR, default 0, 1 = block halts after an error result.
REQ-005 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 in_valid  input  1  sample valid.
REQ-009 in_ready  output  1  block can accept a sample.
REQ-010 p  input  W  sample value, unsigned.
REQ-011 e  input  2  mode code for the sample.
REQ-012 out_valid  output  1  result valid.
REQ-013 out_ready  input  1  downstream accepts result.
REQ-014 c  output  3  one-hot category {c3,c2,c1}; 000 with err=1 on error.
REQ-015 err  output  1  result is uncategorised (error).
REQ-016 clr  input  1  synchronous clear of statistics, sticky flag and HALT state.
REQ-017 cnt1, cnt2, cnt3, cnt_err  output  CW each  saturating counts of accepted results per class.
REQ-018 err_sticky  output  1  set when any error result has been accepted since reset/clr.
REQ-019 halted  output  1  high while FSM is in HALT.

Function
REQ-020 Classification SHALL be: e==00 -> c1; e==01 and p<THRESH -> c2; e[1]==1 and p>=THRESH -> c3; all other cases -> err=1, c=000.
REQ-021 Exactly one of c1,c2,c3,err SHALL be 1 whenever out_valid=1.
REQ-022 Accept occurs when in_valid & in_ready at a rising edge; the result SHALL appear on c/err with out_valid=1 at the next edge (latency 1).
REQ-023 in_ready SHALL equal (state==RUN) & (~out_valid | out_ready); back-to-back accepts at one per cycle are required with out_ready held high.
REQ-024 While out_valid=1 and out_ready=0, c, err and out_valid SHALL hold stable.
REQ-025 out_valid SHALL fall at an edge where out_ready=1 and no new accept occurs.
REQ-026 The counter for the class of an accepted sample SHALL increment by 1 at the accept edge and saturate at 2^CW-1 (no wrap).
REQ-027 err_sticky SHALL set at the accept edge of an error-class sample.
REQ-028 FSM states: RUN, HALT; RUN -> HALT at an error-class accept when HALT_ON_ERR=1; HALT -> RUN on clr=1; otherwise stay.
REQ-029 In HALT, in_ready=0; the pending error result SHALL still be delivered via the normal out_valid/out_ready handshake.
REQ-030 clr=1 SHALL zero all four counters and err_sticky and force RUN at the next edge; clr does not affect out_valid, c or err.
REQ-031 clr coincident with an accept: clear wins; the sample is classified and output but not counted and does not set err_sticky or enter HALT.
REQ-032 With HALT_ON_ERR=0, state SHALL remain RUN permanently and halted=0.
REQ-033 Arithmetic SHALL be unsigned; p compared against THRESH at full W width.

Reset
REQ-034 On rst_n=0, immediately and independent of clk: out_valid=0, c=000, err=0, all counters=0, err_sticky=0, state=RUN, halted=0.
REQ-035 in_ready SHALL be 1 during and after reset (derived combinationally from reset state).
REQ-036 Reset asserted mid-transfer SHALL discard the pending result; no partial counts are retained.
REQ-037 Release of rst_n SHALL be usable asynchronously; first accept is permitted at the first edge after release.

Verification
REQ-038 Defaults, out_ready=1: stream (p,e)=(0,00),(12,01),(13,01),(13,10),(5,11),(15,11) -> c=001,010,err,100,err,100 on consecutive cycles; cnt1=1,cnt2=1,cnt3=2,cnt_err=2,err_sticky=1.
REQ-039 Backpressure: accept (9,01), hold out_ready=0 for 3 cycles -> c=010 stable, in_ready=0, cnt2=1 only; raise out_ready -> in_ready=1 same cycle.
REQ-040 Saturation, CW=2: 5 accepts of (3,00) -> cnt1 sequence 1,2,3,3,3.
REQ-041 HALT_ON_ERR=1: accept (2,10) -> err=1, halted=1, in_ready=0 while in_valid held; clr pulse -> halted=0, in_ready=1, counters and err_sticky=0.
REQ-042 clr in same cycle as accept of (14,11) -> output c=100, cnt3=0 afterwards.
REQ-043 Assert rst_n=0 between edges with out_valid=1 and cnt1=4 -> out_valid=0, cnt1=0 before the next edge.

Source files
------------

// File: rtl/categorizador_stream.sv
// Streaming sample classifier: one-cycle registered result with valid/ready handshake,
// saturating per-class statistics, sticky error flag and optional halt-on-error.
module categorizador_stream #(
  parameter int W           = 4,
  parameter int THRESH      = 13,
  parameter int CW          = 8,
  parameter int HALT_ON_ERR = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  p,
  input  logic [1:0]    e,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [2:0]    c,
  output logic          err,
  input  logic          clr,
  output logic [CW-1:0] cnt1,
  output logic [CW-1:0] cnt2,
  output logic [CW-1:0] cnt3,
  output logic [CW-1:0] cnt_err,
  output logic          err_sticky,
  output logic          halted
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  localparam logic [W-1:0]  THR    = W'(THRESH);
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic          HALT_EN = (HALT_ON_ERR != 0);

  state_t        state_q, state_d;
  logic          out_valid_q, out_valid_d;
  logic [2:0]    c_q, c_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt1_q, cnt1_d;
  logic [CW-1:0] cnt2_q, cnt2_d;
  logic [CW-1:0] cnt3_q, cnt3_d;
  logic [CW-1:0] cnt_err_q, cnt_err_d;
  logic          err_sticky_q, err_sticky_d;

  logic       accept;
  logic [2:0] cls_c;
  logic       cls_err;

  assign in_ready = (state_q == RUN) & (~out_valid_q | out_ready);
  assign accept   = in_valid & in_ready;

  always_comb begin
    cls_c   = 3'b000;
    cls_err = 1'b0;
    if (e == 2'b00)
      cls_c = 3'b001;
    else if ((e == 2'b01) && (p < THR))
      cls_c = 3'b010;
    else if (e[1] && (p >= THR))
      cls_c = 3'b100;
    else
      cls_err = 1'b1;
  end

  // Result register: a new accept overwrites, otherwise a taken result retires.
  always_comb begin
    out_valid_d = out_valid_q;
    c_d         = c_q;
    err_d       = err_q;
    if (accept) begin
      out_valid_d = 1'b1;
      c_d         = cls_c;
      err_d       = cls_err;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Clear dominates a coincident accept: the sample is still delivered but never counted.
  always_comb begin
    cnt1_d       = cnt1_q;
    cnt2_d       = cnt2_q;
    cnt3_d       = cnt3_q;
    cnt_err_d    = cnt_err_q;
    err_sticky_d = err_sticky_q;
    state_d      = state_q;
    if (clr) begin
      cnt1_d       = '0;
      cnt2_d       = '0;
      cnt3_d       = '0;
      cnt_err_d    = '0;
      err_sticky_d = 1'b0;
      state_d      = RUN;
    end else if (accept) begin
      if (cls_c[0] && (cnt1_q != CNT_MAX)) cnt1_d = cnt1_q + 1'b1;
      if (cls_c[1] && (cnt2_q != CNT_MAX)) cnt2_d = cnt2_q + 1'b1;
      if (cls_c[2] && (cnt3_q != CNT_MAX)) cnt3_d = cnt3_q + 1'b1;
      if (cls_err) begin
        if (cnt_err_q != CNT_MAX) cnt_err_d = cnt_err_q + 1'b1;
        err_sticky_d = 1'b1;
        if (HALT_EN) state_d = HALT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      out_valid_q  <= 1'b0;
      c_q          <= 3'b000;
      err_q        <= 1'b0;
      cnt1_q       <= '0;
      cnt2_q       <= '0;
      cnt3_q       <= '0;
      cnt_err_q    <= '0;
      err_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      out_valid_q  <= out_valid_d;
      c_q          <= c_d;
      err_q        <= err_d;
      cnt1_q       <= cnt1_d;
      cnt2_q       <= cnt2_d;
      cnt3_q       <= cnt3_d;
      cnt_err_q    <= cnt_err_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign c          = c_q;
  assign err        = err_q;
  assign cnt1       = cnt1_q;
  assign cnt2       = cnt2_q;
  assign cnt3       = cnt3_q;
  assign cnt_err    = cnt_err_q;
  assign err_sticky = err_sticky_q;
  assign halted     = (state_q == HALT);

endmodule
